// File: rtl/de10boy_pkg.sv
// de10boy_pkg: frame-buffer geometry, shade type and shade-to-grey mapping
// shared by the PPU, the frame buffer and the display scanout.
package de10boy_pkg;

   typedef logic [1:0] shade_t;

   localparam int FB_W = 160;
   localparam int FB_H = 144;

   localparam logic [3:0] GREY_SHADE0 = 4'hF;
   localparam logic [3:0] GREY_SHADE1 = 4'hA;
   localparam logic [3:0] GREY_SHADE2 = 4'h5;
   localparam logic [3:0] GREY_SHADE3 = 4'h0;

   // Sideband travelling alongside a pixel through the RAM read latency.
   typedef struct packed {
      logic hs;
      logic vs;
      logic win;
      logic blank;
   } side_t;

   function automatic logic [3:0] shade_to_grey(input shade_t s);
      logic [3:0] g;
      case (s)
         2'd0:    g = GREY_SHADE0;
         2'd1:    g = GREY_SHADE1;
         2'd2:    g = GREY_SHADE2;
         default: g = GREY_SHADE3;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/frame_scanout_scale_counter.sv
// scale_counter: source/sub-pixel counter pair with load, step and saturate.
// src_o is the coordinate for the current cycle's inputs (zero-latency view of next state).
module scale_counter #(
   parameter int SCALE = 3,
   parameter int MAX   = 160,
   parameter int W     = 8,
   localparam int SW   = (SCALE > 1) ? $clog2(SCALE) : 1
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         load_i,
   input  logic         step_i,
   output logic [W-1:0] src_o
);

   localparam logic [W-1:0]  SRC_LAST = W'(MAX - 1);
   localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);

   logic [W-1:0]  src_q, src_d;
   logic [SW-1:0] sub_q, sub_d;

   always_comb begin
      src_d = src_q;
      sub_d = sub_q;
      if (load_i) begin
         src_d = '0;
         sub_d = '0;
      end else if (step_i) begin
         if (sub_q == SUB_LAST) begin
            sub_d = '0;
            // Saturate rather than wrap so an overlong window repeats the last column.
            if (src_q != SRC_LAST) begin
               src_d = src_q + 1'b1;
            end
         end else begin
            sub_d = sub_q + 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         src_q <= '0;
         sub_q <= '0;
      end else begin
         src_q <= src_d;
         sub_q <= sub_d;
      end
   end

   assign src_o = src_d;

endmodule

// File: rtl/frame_scanout.sv
// frame_scanout: upscaled, centred frame-buffer reader driving the VGA pins; RD_LAT+2 cycles in to pins, no backpressure.
// Define FRAME_SCANOUT_BORDER_EN to paint the visible area outside the window in border grey.
module frame_scanout #(
   parameter int SCALE  = 3,
   parameter int FB_W   = de10boy_pkg::FB_W,
   parameter int FB_H   = de10boy_pkg::FB_H,
   parameter int H_OFS  = 80,
   parameter int V_OFS  = 24,
   parameter int RD_LAT = 1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       hs_in,
   input  logic       vs_in,
   input  logic       blank_in,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   input  logic [7:0] palette,
   output logic [7:0] fb_X_read,
   output logic [7:0] fb_Y_read,
   input  logic [1:0] fb_pixel,
   output logic       frame_start,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic [3:0] VGA_R,
   output logic [3:0] VGA_G,
   output logic [3:0] VGA_B
);
   import de10boy_pkg::*;

   localparam logic [9:0] X_FIRST = 10'(H_OFS);
   localparam logic [9:0] X_LAST  = 10'(H_OFS + FB_W * SCALE - 1);
   localparam logic [9:0] Y_FIRST = 10'(V_OFS);
   localparam logic [9:0] Y_LAST  = 10'(V_OFS + FB_H * SCALE - 1);
   localparam int         DLY     = RD_LAT + 1;
   localparam side_t      SIDE_RST = '{hs: 1'b1, vs: 1'b1, win: 1'b0, blank: 1'b0};
`ifdef FRAME_SCANOUT_BORDER_EN
   localparam logic [3:0] BORDER_GREY = 4'h2;
`endif

   logic       x_in, y_in, x_load, y_load, y_step, in_win;
   logic       x_aligned_q, x_aligned_d;
   logic       y_aligned_q, y_aligned_d;
   logic [7:0] sx, sy;
   logic [7:0] fb_x_q, fb_x_d;
   logic [7:0] fb_y_q, fb_y_d;
   logic       frame_start_q, frame_start_d;
   side_t      side_in, side_al;
   side_t      dl_q [DLY];
   shade_t     shade;
   logic [3:0] rgb_q, rgb_d;
   logic       hs_q, vs_q;

   always_comb begin
      x_in   = (DrawX >= X_FIRST) && (DrawX <= X_LAST);
      y_in   = (DrawY >= Y_FIRST) && (DrawY <= Y_LAST);
      x_load = (DrawX == X_FIRST);
      y_step = (DrawX == '0) && y_in;
      y_load = y_step && (DrawY == Y_FIRST);

      // After a reset the counters mean nothing until the raster passes a load point.
      x_aligned_d = x_aligned_q | x_load;
      y_aligned_d = y_aligned_q | y_load;
      in_win      = x_in && y_in && blank_in && x_aligned_d && y_aligned_q;

      fb_x_d        = in_win ? sx : fb_x_q;
      fb_y_d        = in_win ? sy : fb_y_q;
      frame_start_d = (DrawX == '0) && (DrawY == '0);
      side_in       = '{hs: hs_in, vs: vs_in, win: in_win, blank: blank_in};
   end

   scale_counter #(.SCALE(SCALE), .MAX(FB_W), .W(8)) u_x_cnt (
      .Clk    (Clk),
      .Reset  (Reset),
      .load_i (x_load),
      .step_i (x_in),
      .src_o  (sx)
   );

   scale_counter #(.SCALE(SCALE), .MAX(FB_H), .W(8)) u_y_cnt (
      .Clk    (Clk),
      .Reset  (Reset),
      .load_i (y_load),
      .step_i (y_step),
      .src_o  (sy)
   );

   // Sideband delay matching the address register plus the RAM read latency.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < DLY; i++) begin
            dl_q[i] <= SIDE_RST;
         end
      end else begin
         dl_q[0] <= side_in;
         for (int i = 1; i < DLY; i++) begin
            dl_q[i] <= dl_q[i-1];
         end
      end
   end

   assign side_al = dl_q[DLY-1];
   assign shade   = palette[{fb_pixel, 1'b1} -: 2];

   always_comb begin
      rgb_d = '0;
      if (side_al.blank) begin
         if (side_al.win) begin
            rgb_d = shade_to_grey(shade);
         end
`ifdef FRAME_SCANOUT_BORDER_EN
         else begin
            rgb_d = BORDER_GREY;
         end
`endif
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         x_aligned_q   <= 1'b0;
         y_aligned_q   <= 1'b0;
         fb_x_q        <= '0;
         fb_y_q        <= '0;
         frame_start_q <= 1'b0;
         rgb_q         <= '0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
      end else begin
         x_aligned_q   <= x_aligned_d;
         y_aligned_q   <= y_aligned_d;
         fb_x_q        <= fb_x_d;
         fb_y_q        <= fb_y_d;
         frame_start_q <= frame_start_d;
         rgb_q         <= rgb_d;
         hs_q          <= side_al.hs;
         vs_q          <= side_al.vs;
      end
   end

   assign fb_X_read   = fb_x_q;
   assign fb_Y_read   = fb_y_q;
   assign frame_start = frame_start_q;
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_R       = rgb_q;
   assign VGA_G       = rgb_q;
   assign VGA_B       = rgb_q;

endmodule

// File: tb/tb_frame_scanout.sv
// Directed bench for frame_scanout with default parameters (3x scale, RD_LAT=1).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_frame_scanout;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       hs_in, vs_in, blank_in;
   logic [9:0] DrawX, DrawY;
   logic [7:0] palette;
   logic [7:0] fb_X_read, fb_Y_read;
   logic [1:0] fb_pixel;
   logic       frame_start, VGA_HS, VGA_VS;
   logic [3:0] VGA_R, VGA_G, VGA_B;

   int checks = 0;
   int errors = 0;

`ifdef FRAME_SCANOUT_BORDER_EN
   localparam logic [3:0] BORDER_EXP = 4'h2;
`else
   localparam logic [3:0] BORDER_EXP = 4'h0;
`endif

   always #5 Clk = ~Clk;

   frame_scanout dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .hs_in       (hs_in),
      .vs_in       (vs_in),
      .blank_in    (blank_in),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .palette     (palette),
      .fb_X_read   (fb_X_read),
      .fb_Y_read   (fb_Y_read),
      .fb_pixel    (fb_pixel),
      .frame_start (frame_start),
      .VGA_HS      (VGA_HS),
      .VGA_VS      (VGA_VS),
      .VGA_R       (VGA_R),
      .VGA_G       (VGA_G),
      .VGA_B       (VGA_B)
   );

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input int x, input int y, input logic b);
      DrawX    = 10'(x);
      DrawY    = 10'(y);
      blank_in = b;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rgb(input string tag, input logic [3:0] exp);
      chk({tag, ".R"}, 32'(VGA_R), 32'(exp));
      chk({tag, ".G"}, 32'(VGA_G), 32'(exp));
      chk({tag, ".B"}, 32'(VGA_B), 32'(exp));
   endtask

   initial begin
      Reset    = 1'b1;
      hs_in    = 1'b0;
      vs_in    = 1'b0;
      palette  = 8'hE4;
      fb_pixel = 2'd2;
      drive(300, 23, 1'b1);
      tick();
      tick();
      chk("reset_hs", 32'(VGA_HS), 32'd1);
      chk("reset_vs", 32'(VGA_VS), 32'd1);
      chk_rgb("reset_rgb", 4'h0);
      chk("reset_fbx", 32'(fb_X_read), 32'd0);
      chk("reset_fby", 32'(fb_Y_read), 32'd0);
      chk("reset_frame_start", 32'(frame_start), 32'd0);

      // Leave reset mid-frame: the Y window is loaded, X not yet realigned.
      Reset = 1'b0;
      hs_in = 1'b1;
      vs_in = 1'b1;
      drive(0, 24, 1'b0);
      tick();
      for (int x = 200; x <= 203; x++) begin
         drive(x, 24, 1'b1);
         tick();
      end
      chk_rgb("unaligned_rgb", BORDER_EXP);

      // Address ramp across line 24, with latency and palette switch checks.
      for (int x = 80; x <= 562; x++) begin
         drive(x, 24, 1'b1);
         if (x == 300) palette = 8'h1B;
         tick();
         chk("ramp_fbx", 32'(fb_X_read), (x <= 559) ? 32'((x - 80) / 3) : 32'd159);
         if (x == 81)  chk_rgb("pre_window_rgb", BORDER_EXP);
         if (x == 82)  chk_rgb("first_pixel_e4", 4'h5);
         if (x == 299) chk_rgb("last_e4_pixel", 4'h5);
         if (x == 300) chk_rgb("first_1b_pixel", 4'hA);
         if (x == 100) chk("ramp_fby", 32'(fb_Y_read), 32'd0);
         if (x == 562) chk_rgb("post_window_rgb", BORDER_EXP);
      end

      // Glitching raster: DrawX==80 mid-window forces X back to column 0.
      drive(0, 25, 1'b0);
      tick();
      for (int x = 80; x <= 95; x++) begin
         drive(x, 25, 1'b1);
         tick();
      end
      chk("pre_resync_fbx", 32'(fb_X_read), 32'd5);
      drive(80, 25, 1'b1);
      tick();
      chk("resync_fbx", 32'(fb_X_read), 32'd0);
      drive(81, 25, 1'b1);
      tick();
      drive(82, 25, 1'b1);
      tick();
      drive(83, 25, 1'b1);
      tick();
      chk("resync_step_fbx", 32'(fb_X_read), 32'd1);
      chk("line25_fby", 32'(fb_Y_read), 32'd0);

      // Line replay down to the last source row.
      for (int y = 26; y <= 455; y++) begin
         drive(0, y, 1'b0);
         tick();
         drive(80, y, 1'b1);
         tick();
         if (y == 26)  chk("line26_fby", 32'(fb_Y_read), 32'd0);
         if (y == 27)  chk("line27_fby", 32'(fb_Y_read), 32'd1);
         if (y == 30)  chk("line30_fby", 32'(fb_Y_read), 32'd2);
         if (y == 455) chk("line455_fby", 32'(fb_Y_read), 32'd143);
      end

      drive(0, 456, 1'b0);
      tick();
      for (int x = 80; x <= 82; x++) begin
         drive(x, 456, 1'b1);
         tick();
      end
      chk_rgb("line456_rgb", BORDER_EXP);
      chk("line456_fby_hold", 32'(fb_Y_read), 32'd143);
      chk("line456_fbx_hold", 32'(fb_X_read), 32'd0);

      // Sync alignment: edge at cycle n reaches the pin at n+3.
      drive(600, 456, 1'b0);
      tick();
      tick();
      tick();
      hs_in = 1'b0;
      tick();
      chk("hs_n1", 32'(VGA_HS), 32'd1);
      tick();
      chk("hs_n2", 32'(VGA_HS), 32'd1);
      tick();
      chk("hs_n3", 32'(VGA_HS), 32'd0);
      hs_in = 1'b1;
      tick();
      tick();
      chk("hs_rise_n2", 32'(VGA_HS), 32'd0);
      tick();
      chk("hs_rise_n3", 32'(VGA_HS), 32'd1);

      vs_in = 1'b0;
      tick();
      tick();
      chk("vs_n2", 32'(VGA_VS), 32'd1);
      tick();
      chk("vs_n3", 32'(VGA_VS), 32'd0);
      vs_in = 1'b1;
      tick();
      tick();
      tick();
      chk("vs_rise_n3", 32'(VGA_VS), 32'd1);

      // Border versus blanking in the visible area left of the window.
      drive(10, 100, 1'b0);
      tick();
      tick();
      tick();
      chk_rgb("blanked_rgb", 4'h0);
      drive(10, 100, 1'b1);
      tick();
      tick();
      tick();
      chk_rgb("border_rgb", BORDER_EXP);

      drive(0, 0, 1'b0);
      tick();
      chk("frame_start_pulse", 32'(frame_start), 32'd1);
      drive(1, 0, 1'b0);
      tick();
      chk("frame_start_clear", 32'(frame_start), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_scanout.md
# frame_scanout

Display-side reader of the 160x144 2-bit frame buffer. It takes raster coordinates and sync from `vga_controller`, generates frame-buffer read addresses, and applies integer upscaling (default 3x) with centring. It maps each 2-bit shade through a BGP-format palette to 4-bit grey, delay-matches HS/VS/blank to the RAM read latency, and drives the VGA pins. It replaces the ad-hoc combinational colour mapping at top level and fixes the bug where `DrawX[7:0]`/`DrawY[7:0]` were used directly as buffer addresses.

## Interface
Parameters:
- `SCALE`, 3: integer upscale factor, applied identically in X and Y; legal range 1..3.
- `FB_W`, 160: frame-buffer width in source pixels.
- `FB_H`, 144: frame-buffer height in source lines.
- `H_OFS`, 80: first active DrawX; window is H_OFS..H_OFS+FB_W*SCALE-1.
- `V_OFS`, 24: first active DrawY; window is V_OFS..V_OFS+FB_H*SCALE-1.
- `RD_LAT`, 1: frame-buffer read latency in Clk cycles, from registered address to valid `fb_pixel`.

Ports:
- `Clk` in 1: pixel clock; one raster pixel per cycle.
- `Reset` in 1: synchronous, active-high.
- `hs_in` in 1: active-low HS from `vga_controller`.
- `vs_in` in 1: active-low VS from `vga_controller`.
- `blank_in` in 1: 1 = visible region.
- `DrawX` in 10: current raster X.
- `DrawY` in 10: current raster Y.
- `palette` in 8: BGP format; shade for colour i is `palette[2i+1:2i]`.
- `fb_X_read` out 8: frame-buffer read column (registered).
- `fb_Y_read` out 8: frame-buffer read row (registered).
- `fb_pixel` in 2: frame-buffer read data.
- `frame_start` out 1: one-cycle pulse when raster is at (0,0).
- `VGA_HS` out 1: delayed HS.
- `VGA_VS` out 1: delayed VS.
- `VGA_R` out 4: red output.
- `VGA_G` out 4: green output.
- `VGA_B` out 4: blue output.

## Operation
- X counters `sx` (0..FB_W-1) and `subx` (0..SCALE-1):
  - When DrawX==H_OFS: sx=0, subx=0.
  - Otherwise, inside the window: subx increments; when subx==SCALE-1, subx wraps to 0 and sx increments.
  - sx saturates at FB_W-1; it never wraps to 0 inside the window.
- Y counters `sy` (0..FB_H-1) and `suby` (0..SCALE-1) update only on cycles where DrawX==0:
  - DrawY==V_OFS: sy=0, suby=0.
  - DrawY inside the window (excluding V_OFS): suby steps with the same wrap rule, and sy advances.
- `in_win` is DrawX in the X window AND DrawY in the Y window AND blank_in.
- Address stage (registered): fb_X_read<=sx, fb_Y_read<=sy, in_win_d<=in_win. Outside the window, addresses hold their previous value.
- Delay line: {hs_in, vs_in, in_win, blank_in} delayed by RD_LAT+1 cycles so they align with `fb_pixel`.
- Palette: shade = palette[2*fb_pixel+1 -: 2]. Shade-to-grey mapping: 0→4'hF, 1→4'hA, 2→4'h5, 3→4'h0. R, G and B are all driven with this grey value.
- Output register selection:
  - aligned in_win: grey.
  - aligned blank_in=1 but outside window: BORDER (see Configuration).
  - blank_in=0: 0.
- `palette` is sampled in the output stage. A change takes effect on the next output pixel; there is no frame-boundary interlock.
- `frame_start` is registered: it is 1 in the cycle after DrawX==0 && DrawY==0 is sampled.

## Timing
- Total latency is RD_LAT+2 cycles from sampled inputs (DrawX/DrawY/syncs) to the VGA pins, for pixels and syncs alike. With the default RD_LAT=1 this is 3 cycles.
- Addresses appear 1 cycle after the DrawX/DrawY that produced them.
- Reset values (asserted in the cycle after Reset is sampled high):
  - VGA_HS=1, VGA_VS=1.
  - RGB=0.
  - fb_X_read=0, fb_Y_read=0.
  - frame_start=0.
  - All counters 0.
  - All delay-line stages set to {1,1,0,0}.
- Reset mid-line: outputs stay black until the next DrawX==H_OFS realigns the counters. No partial-frame garbage appears at the wrong offset.
- DrawX==H_OFS arriving while already inside a window (a glitching raster) forces a resync to sx=0.
- SCALE=1: subx and suby are constant 0; sx and sy advance every pixel and every line.

## Configuration
- `FRAME_SCANOUT_BORDER_EN` defined: the visible area outside the window shows border grey 4'h2 on R/G/B.
- Not defined: the area outside the window is 0 (black). The border comparison logic is not built.

## Structure
- Shared package `de10boy_pkg` holds:
  - `shade_t` (logic [1:0]).
  - `FB_W`/`FB_H` constants (shared with `ppu` and `frame_buffer`).
  - The `shade_to_grey` function and its 4 grey constants.
- One sub-module, `scale_counter`: the source/sub-pixel counter pair with load, step and saturate. It is instantiated twice (X, and Y with step=DrawX==0).
- Delay line is an inline parameterised shift register.

## Test plan
- **Reset:** Reset held 2 cycles mid-line -> VGA_HS=VGA_VS=1, RGB=0, fb_X_read=fb_Y_read=0. Output stays black until DrawX==80.
- **Address ramp:** DrawY=24, DrawX 80..559 -> fb_X_read goes 0,0,0,1,1,1..159,159,159 starting 1 cycle later; fb_Y_read=0. At DrawX=560 the address holds 159.
- **Line replay:** DrawY 24,25,26,27 -> fb_Y_read 0,0,0,1. DrawY=455 -> 143. DrawY=456 -> outside window (black).
- **Palette and latency:** fb_pixel forced 2, palette=8'hE4 at DrawX=80 -> RGB=4'h5 on all channels, RD_LAT+2=3 cycles after DrawX=80 is sampled. Same with palette=8'h1B -> 4'hA.
- **Sync alignment:** hs_in falling edge at cycle n -> VGA_HS falls at n+3. VS behaves the same.
- **Border:** blank_in=1, DrawX=10 -> RGB=4'h2 with FRAME_SCANOUT_BORDER_EN defined, 0 without.
